// File: rtl/conv33_window_collector.sv
// Keeps 3x3 sums whose window lies fully inside the image and queues them on a valid/ready FIFO.
// Optional sticky drop flag `ovf` is built when CONV33_WC_OVF_EN is defined.
module conv33_window_collector #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned IMG_W      = 64,
    parameter int unsigned IMG_H      = 64,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             frame_done
`ifdef CONV33_WC_OVF_EN
   ,output logic             ovf
`endif
);

    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned PW    = AW + 1;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             last;
    } entry_t;

    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic             r_out_valid;
    logic             r_frame_done;
    entry_t           r_mem [FIFO_DEPTH];

    logic             w_col_end;
    logic             w_row_end;
    logic             w_last_px;
    logic             w_win;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic [PW-1:0]    w_wr_nxt;
    logic [PW-1:0]    w_rd_nxt;

    assign w_col_end = (r_col == COL_W'(IMG_W - 1));
    assign w_row_end = (r_row == ROW_W'(IMG_H - 1));
    assign w_last_px = w_col_end && w_row_end;
    assign w_win     = in_valid && (r_row >= ROW_W'(2)) && (r_col >= COL_W'(2));

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop     = r_out_valid && out_ready;
    assign w_push    = w_win && (!w_full || w_pop);
    assign w_drop    = w_win && w_full && !w_pop;
    assign w_wr_nxt  = r_wr_ptr + PW'(w_push);
    assign w_rd_nxt  = r_rd_ptr + PW'(w_pop);

    // Raster position of the next accepted pixel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_col <= '0;
            r_row <= '0;
        end else if (in_valid) begin
            if (w_col_end) begin
                r_col <= '0;
                r_row <= w_row_end ? '0 : r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_wr_ptr     <= w_wr_nxt;
            r_rd_ptr     <= w_rd_nxt;
            r_out_valid  <= (w_wr_nxt != w_rd_nxt);
            r_frame_done <= in_valid && w_last_px;
        end
    end

    // Storage is cleared so the head reads as zero out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= '{data: in_data, last: w_last_px};
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_mem[r_rd_ptr[AW-1:0]].data;
    assign out_last   = r_mem[r_rd_ptr[AW-1:0]].last;
    assign frame_done = r_frame_done;

`ifdef CONV33_WC_OVF_EN
    logic r_ovf;

    // Sticky until reset; frame wrap leaves it alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end
    end

    assign ovf = r_ovf;
`else
    logic w_drop_unused;
    assign w_drop_unused = w_drop;
`endif

endmodule

// File: tb/tb_conv33_window_collector.sv
// Randomized and directed bench for conv33_window_collector against a queue-based reference model.
module tb_conv33_window_collector;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned IMG_W = 4;
    localparam int unsigned IMG_H = 4;
    localparam int unsigned DEPTH = 4;
    localparam int          NPIX  = IMG_W * IMG_H;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             frame_done;
`ifdef CONV33_WC_OVF_EN
    logic             ovf;
`endif

    conv33_window_collector #(
        .WIDTH      (WIDTH),
        .IMG_W      (IMG_W),
        .IMG_H      (IMG_H),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .frame_done (frame_done)
`ifdef CONV33_WC_OVF_EN
       ,.ovf        (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic             l;
    } exp_t;

    int               n_checks = 0;
    int               n_errors = 0;
    exp_t             exp_q[$];
    int               m_k;
    bit               m_fd;
    bit               m_ovf;
    logic [WIDTH-1:0] got_d[$];
    logic             got_l[$];
    int               fd_seen;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            chk("out_data", 32'(out_data), 32'(exp_q[0].d));
            chk("out_last", 32'(out_last), 32'(exp_q[0].l));
        end
        chk("frame_done", 32'(frame_done), 32'(m_fd));
`ifdef CONV33_WC_OVF_EN
        chk("ovf", 32'(ovf), 32'(m_ovf));
`endif
        if (frame_done) fd_seen++;
    endtask

    // Reference: linear pixel index k; row/col follow by division.
    task automatic model_advance(input logic v, input logic [WIDTH-1:0] d, input logic rdy);
        int  r, c;
        bit  pop, win, full;
        exp_t e;
        r    = m_k / IMG_W;
        c    = m_k % IMG_W;
        pop  = (exp_q.size() != 0) && rdy;
        win  = v && (r >= 2) && (c >= 2);
        full = (exp_q.size() == DEPTH);
        if (pop) void'(exp_q.pop_front());
        if (win) begin
            if (!full || pop) begin
                e.d = d;
                e.l = (r == IMG_H - 1) && (c == IMG_W - 1);
                exp_q.push_back(e);
            end else begin
                m_ovf = 1'b1;
            end
        end
        m_fd = v && (m_k == NPIX - 1);
        if (v) m_k = (m_k + 1) % NPIX;
    endtask

    task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic rdy);
        @(negedge clk);
        check_outputs();
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        if (out_valid && rdy) begin
            got_d.push_back(out_data);
            got_l.push_back(out_last);
        end
        model_advance(v, d, rdy);
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        reset     = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_out_data", 32'(out_data), 32'(0));
        chk("rst_out_last", 32'(out_last), 32'(0));
        chk("rst_frame_done", 32'(frame_done), 32'(0));
`ifdef CONV33_WC_OVF_EN
        chk("rst_ovf", 32'(ovf), 32'(0));
`endif
        exp_q.delete();
        m_k   = 0;
        m_fd  = 1'b0;
        m_ovf = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic clear_log();
        got_d.delete();
        got_l.delete();
        fd_seen = 0;
    endtask

    task automatic feed(input int base, input int n, input bit gaps, input logic rdy);
        for (int i = 0; i < n; i++) begin
            step(1'b1, WIDTH'(base + i), rdy);
            if (gaps) step(1'b0, WIDTH'($urandom), rdy);
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1);
    endtask

    task automatic check_seq(input string tag, input int ev[$]);
        chk({tag, "_count"}, 32'(got_d.size()), 32'(ev.size()));
        for (int i = 0; i < ev.size() && i < got_d.size(); i++) begin
            chk({tag, "_data"}, 32'(got_d[i]), 32'(ev[i]));
            chk({tag, "_last"}, 32'(got_l[i]), 32'((ev[i] % 16) == 15));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int ev[$];
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        m_k       = 0;
        m_fd      = 1'b0;
        m_ovf     = 1'b0;
        fd_seen   = 0;
        repeat (2) @(negedge clk);
        do_reset();

        // Nominal frame
        clear_log();
        feed(0, 16, 1'b0, 1'b1);
        drain(4);
        ev = '{10, 11, 14, 15};
        check_seq("nominal", ev);
        chk("nominal_fd", 32'(fd_seen), 32'(1));

        // Alternate-cycle gaps
        do_reset();
        clear_log();
        feed(0, 16, 1'b1, 1'b1);
        drain(4);
        check_seq("gaps", ev);
        chk("gaps_fd", 32'(fd_seen), 32'(1));

        // Back-to-back frames
        do_reset();
        clear_log();
        feed(0, 32, 1'b0, 1'b1);
        drain(4);
        ev = '{10, 11, 14, 15, 26, 27, 30, 31};
        check_seq("b2b", ev);
        chk("b2b_fd", 32'(fd_seen), 32'(2));

        // Overflow: second frame's windows are dropped
        do_reset();
        clear_log();
        feed(0, 32, 1'b0, 1'b0);
        drain(6);
        ev = '{10, 11, 14, 15};
        check_seq("overflow", ev);
        chk("overflow_fd", 32'(fd_seen), 32'(2));
`ifdef CONV33_WC_OVF_EN
        chk("overflow_sticky", 32'(ovf), 32'(1));
`endif

        // Push and pop together while full
        do_reset();
        clear_log();
        feed(0, 26, 1'b0, 1'b0);
        step(1'b1, WIDTH'(26), 1'b1);
        step(1'b0, '0, 1'b0);
        chk("simul_full_hold", 32'(out_valid), 32'(1));
`ifdef CONV33_WC_OVF_EN
        chk("simul_no_ovf", 32'(ovf), 32'(0));
`endif
        drain(6);
        ev = '{10, 11, 14, 15, 26};
        check_seq("simul", ev);

        // Reset mid-frame with entries queued
        do_reset();
        feed(0, 12, 1'b0, 1'b0);
        do_reset();
        clear_log();
        feed(0, 16, 1'b0, 1'b1);
        drain(4);
        ev = '{10, 11, 14, 15};
        check_seq("midreset", ev);

        // Randomized traffic against the model
        do_reset();
        for (int ph = 0; ph < 4; ph++) begin
            int rdy_pct;
            rdy_pct = (ph == 0) ? 90 : (ph == 1) ? 30 : (ph == 2) ? 5 : 60;
            for (int i = 0; i < 800; i++) begin
                step(($urandom_range(0, 3) != 0), WIDTH'($urandom),
                     ($urandom_range(0, 99) < rdy_pct));
            end
            if (ph == 1) do_reset();
        end
        drain(8);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
